pixel_writer: RTL and testbench

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/pixel_writer.sv | 111 +++++++++++
 tb/tb_pixel_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_writer.sv
// Raster pixel writer: accepts a 2^COORD_W x 2^COORD_W frame of pixels and emits registered
// frame-buffer writes. Optional XOR checksum enabled by defining PIXEL_WRITER_CKSUM_EN.
//   state  | meaning
//   IDLE   | waiting for start; pixels here are protocol errors
//   ACTIVE | accepting pixels in raster order
//   DONE   | one-cycle frame_done, coincides with the final write
module pixel_writer #(
  parameter int COORD_W = 4,
  parameter int DATA_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 wr_en,
  output logic [2*COORD_W-1:0] wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 err,
  output logic [DATA_W-1:0]    cksum
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  state_t state, state_nxt;
  logic [COORD_W-1:0] col, row;
  logic xfer, last_pix, clear;

  assign xfer     = pix_valid & pix_ready;
  assign last_pix = (col == COORD_MAX) && (row == COORD_MAX);
  // start is honoured in IDLE (arm) and ACTIVE (abort), ignored in DONE
  assign clear    = start && (state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACTIVE;
      ACTIVE:  if (xfer && last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix_ready  = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    if (state == ACTIVE) pix_ready = ~start;
    if (state != IDLE)   busy = 1'b1;
    if (state == DONE)   frame_done = 1'b1;
  end

  // Coordinates wrap naturally; row advances when col rolls over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      col <= col + 1'b1;
      if (col == COORD_MAX) row <= row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer) begin
        wr_addr <= {row, col};
        wr_data <= pix_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             err <= 1'b0;
    else if (clear)                                        err <= 1'b0;
    else if (pix_valid && (state == IDLE || state == DONE)) err <= 1'b1;
  end

`ifdef PIXEL_WRITER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cksum_q <= '0;
    else if (clear) cksum_q <= '0;
    else if (xfer)  cksum_q <= cksum_q ^ pix_data;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: full frame, row wrap, stall, abort, error flag,
// asynchronous reset mid-frame and checksum.
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, start, pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready, wr_en, frame_done, busy, err;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data, cksum;

  int checks = 0;
  int errors = 0;
  logic [31:0] ck_first, ck_final;

  pixel_writer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .busy       (busy),
    .err        (err),
    .cksum      (cksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PIXEL_WRITER_CKSUM_EN
    ck_first = 32'h1;
    ck_final = 32'h3;
`else
    ck_first = 32'h0;
    ck_final = 32'h0;
`endif
    start = 1'b0; pix_valid = 1'b0; pix_data = '0; reset = 1'b1;
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cksum", cksum, 0);
    check("rst_pix_ready", pix_ready, 0);
    #20;
    step();
    reset = 1'b0;

    // Full frame, back-to-back
    start = 1'b1;
    #1 check("idle_ready", pix_ready, 0);
    step();
    check("armed_busy", busy, 1);
    check("start_blocks_ready", pix_ready, 0);
    start = 1'b0;
    #1 check("active_ready", pix_ready, 1);
    for (int i = 0; i < 256; i++) begin
      pix_valid = 1'b1;
      pix_data  = 16'(i);
      step();
      check("f1_wr_en", wr_en, 1);
      check("f1_wr_addr", wr_addr, 32'(i));
      check("f1_wr_data", wr_data, 32'(i));
      check("f1_frame_done", frame_done, (i == 255) ? 1 : 0);
    end
    pix_valid = 1'b0;
    check("f1_done_busy", busy, 1);
    check("f1_cksum", cksum, 0);
    step();
    check("f1_after_wr_en", wr_en, 0);
    check("f1_after_done", frame_done, 0);
    check("f1_after_busy", busy, 0);
    check("f1_after_err", err, 0);

    // Pixel offered in IDLE sets sticky err; start clears it
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    check("idle_err_set", err, 1);
    check("idle_no_wr", wr_en, 0);
    check("idle_busy", busy, 0);
    step();
    check("err_sticky", err, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_cleared", err, 0);
    check("f2_busy", busy, 1);

    // Row wrap at col 15 and a mid-frame stall
    for (int i = 0; i < 49; i++) begin
      if (i == 20) begin
        pix_valid = 1'b0;
        repeat (3) step();
        check("stall_wr_en", wr_en, 0);
        check("stall_addr_hold", wr_addr, 19);
        check("stall_err", err, 0);
      end
      pix_valid = 1'b1;
      pix_data  = 16'hA000 + 16'(i);
      step();
      check("f2_wr_en", wr_en, 1);
      check("f2_wr_addr", wr_addr, 32'(i));
      check("f2_wr_data", wr_data, 32'hA000 + 32'(i));
    end
    check("wrap_addr_30", wr_addr, 32'h30);

    // Abort while a pixel is offered
    start = 1'b1;
    pix_data = 16'hBEEF;
    #1 check("abort_ready", pix_ready, 0);
    step();
    check("abort_no_wr", wr_en, 0);
    check("abort_addr_hold", wr_addr, 32'h30);
    check("abort_busy", busy, 1);
    check("abort_no_done", frame_done, 0);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pix_data = 16'h0100 + 16'(i);
      step();
      check("f3_wr_addr", wr_addr, 32'(i));
    end
    start = 1'b1;
    step();
    check("abort2_no_wr", wr_en, 0);
    start = 1'b0;
    pix_data = 16'hCAFE;
    step();
    check("restart_wr_en", wr_en, 1);
    check("restart_addr", wr_addr, 0);
    check("restart_data", wr_data, 32'hCAFE);
    check("restart_no_done", frame_done, 0);

    // Advance to row 5, then reset asynchronously with a write pending
    for (int i = 1; i < 83; i++) begin
      pix_data = 16'(i);
      step();
    end
    check("pre_rst_addr", wr_addr, 32'h52);
    check("pre_rst_wr_en", wr_en, 1);
    reset = 1'b1;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_busy", busy, 0);
    check("arst_done", frame_done, 0);
    check("arst_ready", pix_ready, 0);
    pix_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_done", frame_done, 0);
    check("post_rst_wr_en", wr_en, 0);
    check("post_rst_busy", busy, 0);

    // Checksum frame: 1, 2, then zeros
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pix_valid = 1'b1;
      pix_data  = (i == 0) ? 16'h0001 : (i == 1) ? 16'h0002 : 16'h0000;
      step();
      if (i == 0) check("ck_first", cksum, ck_first);
    end
    pix_valid = 1'b0;
    check("ck_done", frame_done, 1);
    check("ck_final", cksum, ck_final);
    check("ck_last_addr", wr_addr, 32'hFF);
    start = 1'b1;
    step();
    check("done_ignores_start", busy, 0);
    step();
    start = 1'b0;
    check("rearm_busy", busy, 1);
    check("rearm_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
